// File: rtl/arbitro_capa.sv
// arbitro_capa: routing arbiter of the transaction layer.
// Pops one word per cycle from four input FIFOs, decodes the destination from
// the word's two MSBs and pushes it to the matching output FIFO two cycles later.
// Optional feature macro: ARB_ROUND_ROBIN_EN (rotating priority); when undefined
// the arbiter uses fixed priority, input 0 highest.
module arbitro_capa #(
    parameter int unsigned DATA_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Enable,
    input  logic [3:0]            fifo_empty,
    input  logic [DATA_WIDTH-1:0] data_in_p0,
    input  logic [DATA_WIDTH-1:0] data_in_p1,
    input  logic [DATA_WIDTH-1:0] data_in_p2,
    input  logic [DATA_WIDTH-1:0] data_in_p3,
    input  logic [3:0]            almost_full_out,
    output logic [3:0]            pop_in,
    output logic [3:0]            push_out,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  idle
);

    localparam int unsigned N_PORTS  = 4;
    localparam int unsigned IDX_W    = 2;
    localparam int unsigned DEST_MSB = DATA_WIDTH - 1;

    logic                  stall;
    logic                  grant_vld;
    logic [IDX_W-1:0]      grant_idx;

    logic [IDX_W-1:0]      sel_q, sel_d;
    logic                  vld_q, vld_d;
    logic [N_PORTS-1:0]    push_q, push_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  idle_q, idle_d;
    logic [DATA_WIDTH-1:0] route_word;
    logic [IDX_W-1:0]      route_dest;

`ifdef ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0]      ptr_q, ptr_d;
    logic [IDX_W-1:0]      cand;
`endif

    // Stall blocks new grants only; words already popped still drain.
    assign stall = reset | ~Enable | (|almost_full_out);

    // Grant: pick one non-empty input and pop it this cycle.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        pop_in    = '0;
`ifdef ARB_ROUND_ROBIN_EN
        cand      = '0;
        for (int k = 0; k < N_PORTS; k++) begin
            cand = ptr_q + IDX_W'(k);
            if (!grant_vld && !fifo_empty[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
`else
        for (int k = N_PORTS - 1; k >= 0; k--) begin
            if (!fifo_empty[k]) begin
                grant_vld = 1'b1;
                grant_idx = IDX_W'(k);
            end
        end
`endif
        if (stall) begin
            grant_vld = 1'b0;
        end
        if (grant_vld) begin
            pop_in[grant_idx] = 1'b1;
        end
    end

    // Route: read data of the input popped last cycle and decode its destination.
    always_comb begin
        route_word = data_in_p0;
        case (sel_q)
            2'd0:    route_word = data_in_p0;
            2'd1:    route_word = data_in_p1;
            2'd2:    route_word = data_in_p2;
            default: route_word = data_in_p3;
        endcase
        route_dest = route_word[DEST_MSB -: IDX_W];
    end

    // Next-state for the capture and push stages.
    always_comb begin
        sel_d  = grant_vld ? grant_idx : sel_q;
        vld_d  = grant_vld;
        push_d = '0;
        data_d = data_q;
        if (vld_q) begin
            push_d = N_PORTS'(1) << route_dest;
            data_d = route_word;
        end
        idle_d = (&fifo_empty) & ~vld_q;
    end

`ifdef ARB_ROUND_ROBIN_EN
    // Pointer moves past the winner; holds when nothing is granted.
    always_comb begin
        ptr_d = ptr_q;
        if (grant_vld) begin
            ptr_d = grant_idx + IDX_W'(1);
        end
    end

    // Rotating-priority pointer register.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    // Pipeline registers; reset drops any in-flight word.
    always_ff @(posedge clk) begin
        if (reset) begin
            sel_q  <= '0;
            vld_q  <= 1'b0;
            push_q <= '0;
            data_q <= '0;
            idle_q <= 1'b1;
        end else begin
            sel_q  <= sel_d;
            vld_q  <= vld_d;
            push_q <= push_d;
            data_q <= data_d;
            idle_q <= idle_d;
        end
    end

    assign push_out = push_q;
    assign data_out = data_q;
    assign idle     = idle_q;

endmodule

// File: doc/arbitro_capa.md
# arbitro_capa

Routing arbiter of the transaction layer. Moves 12-bit words from four input FIFOs to four output FIFOs, one word per cycle: picks one non-empty input, pops it, decodes destination from the word's two MSBs and pushes to the matching output FIFO. Throttles all traffic when any output FIFO reports almost-full. Sits between the input FIFO bank and the output FIFO bank, under the layer FSM (`Enable`, `idle`).

## Interface
- `DATA_WIDTH`, 12, word width; destination field is `[DATA_WIDTH-1:DATA_WIDTH-2]`
- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high; clears all state
- `Enable`  in  1  arbitration enable; low blocks new pops
- `fifo_empty`  in  4  empty flag per input FIFO, bit i = input i
- `data_in_p0`..`data_in_p3`  in  DATA_WIDTH each  input FIFO read data, valid the cycle after its pop
- `almost_full_out`  in  4  almost-full flag per output FIFO
- `pop_in`  out  4  one-hot pop to input FIFOs (combinational)
- `push_out`  out  4  one-hot push to output FIFOs (registered)
- `data_out`  out  DATA_WIDTH  word for the output FIFOs, valid with `push_out` (registered)
- `idle`  out  1  no activity and nothing pending (registered)

## Operation
- Stall = `reset` | ~`Enable` | (|`almost_full_out`). Stall blocks new grants only; in-flight words finish.
- Grant (cycle t, combinational): if not stalled and `fifo_empty` != 4'b1111, assert `pop_in[g]` for winner g per priority rule; else `pop_in` = 0. At most one bit set.
- Capture (edge end of t): `sel_q` <= g, `vld_q` <= 1 if a pop happened, else `vld_q` <= 0.
- Route (cycle t+1): word = `data_in_p[sel_q]`; dest = word[DATA_WIDTH-1:DATA_WIDTH-2]. At end of t+1, if `vld_q`: `data_out` <= word, `push_out` <= 1 << dest; else `push_out` <= 0, `data_out` holds.
- Pipelined: new grant every cycle; sustained throughput 1 word/cycle.
- Destinations: 00->out0, 01->out1, 10->out2, 11->out3. Word passed unmodified.
- `idle` <= 1 when `fifo_empty` = 4'b1111, `vld_q` = 0 and `push_out` next = 0; else 0.
- Output FIFO almost-full threshold must leave ≥2 free slots (two words can be in flight after flag rises).
- Simultaneous almost-full on several outputs: same global stall, no ordering effect.
- Input FIFO becoming empty the same cycle it is popped: handled by FIFO; arbiter only samples `fifo_empty` in the grant cycle.
- Reset mid-operation: `vld_q`, `sel_q`, `push_out`, `data_out`, priority pointer cleared next edge; in-flight words dropped.

## Timing
- Reset values: `pop_in` = 0 (forced while `reset` high), `push_out` = 0, `data_out` = 0, `idle` = 1, `sel_q` = 0, `vld_q` = 0, RR pointer = 0.
- Latency pop -> push: 2 cycles (pop in t, push asserted in t+2).
- `Enable` falling in t: no pop in t; pops from t-1, t-2 still push.
- Almost-full rising in t: `pop_in` = 0 in t itself.
- `idle` lags activity by one cycle.

## Configuration
- `ARB_ROUND_ROBIN_EN` defined: rotating priority. 2-bit pointer p; search order p, p+1, p+2, p+3 (mod 4); after a grant to g, p <= g+1 mod 4; pointer unchanged without grant.
- Undefined: fixed priority, input 0 highest, then 1, 2, 3; no pointer register.

## Test plan
- Reset: hold `reset`=1 3 cycles with inputs non-empty -> `pop_in`=0, `push_out`=0, `data_out`=0, `idle`=1 throughout.
- Routing: input 0 holds 0x0AA, 0x5AA, 0xAAA, 0xFAA, others empty, `Enable`=1 -> `pop_in`=0001 four consecutive cycles; `push_out`=0001,0010,0100,1000 from 2 cycles later with matching `data_out`.
- Priority (macro undefined): all four inputs non-empty with 2 words each -> pops 0,0,1,1,2,2,3,3. With `ARB_ROUND_ROBIN_EN`: pops 0,1,2,3,0,1,2,3.
- Back-pressure: stream of 0x5xx words, raise `almost_full_out[1]` at cycle t -> `pop_in`=0 from t; at most 2 pushes after t; resumes first cycle flag drops.
- Enable gating: drop `Enable` mid-stream -> pops stop same cycle, last two words still pushed, `idle` rises once inputs empty; re-assert -> traffic resumes in order.
- Reset mid-flight: assert `reset` the cycle after a pop -> no push for that word, `push_out`=0 next edge, RR pointer back to 0.
